// File: rtl/snake_tick_gen.sv
// snake_tick_gen: periodic game tick with a speed level that shortens the period.
// An IDLE/RUN/PAUSED FSM gates a period counter. Each speed level shortens the
// period by STEP cycles, down to a floor of MIN_PERIOD. The period in use is
// latched at every wrap, so a level change does not take effect until the
// current period has completed.
// Optional build macro: SNAKE_TICK_SQUARE_EN adds tick_sq, a square wave that
// toggles once per tick.
module snake_tick_gen #(
    parameter int BASE_PERIOD = 25000000,
    parameter int STEP        = 2500000,
    parameter int MIN_PERIOD  = 5000000,
    parameter int LEVELS      = 8,
    parameter int CNT_W       = 27,
    // derived; do not override
    parameter int LVL_W       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pause,
    input  logic             speed_up,
    input  logic             speed_clr,
    output logic             tick,
    output logic [LVL_W-1:0] level,
    output logic             at_max,
    output logic             running
`ifdef SNAKE_TICK_SQUARE_EN
    ,
    output logic             tick_sq
`endif
);

    // One spare bit on the period math so BASE - level*STEP cannot wrap.
    localparam int PW = CNT_W + 1;
    // Product width: wide enough that level*STEP can never overflow.
    localparam int DW = PW + LVL_W;

    localparam logic [PW-1:0]    BASE_C  = PW'(BASE_PERIOD);
    localparam logic [PW-1:0]    STEP_C  = PW'(STEP);
    localparam logic [PW-1:0]    MIN_C   = PW'(MIN_PERIOD);
    localparam logic [PW-1:0]    P0      = (BASE_C > MIN_C) ? BASE_C : MIN_C;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    period_q, period_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             tick_q, tick_d;

    logic [DW-1:0]    dec;
    logic [PW-1:0]    diff;
    logic [PW-1:0]    p_now;
    logic             last;
    logic             advance;

    // Period for the current level: max(BASE - level*STEP, MIN) with no underflow.
    always_comb begin
        dec   = DW'(level_q) * DW'(STEP_C);
        diff  = '0;
        p_now = MIN_C;
        if (dec < DW'(BASE_C)) begin
            diff = BASE_C - PW'(dec);
            if (diff > MIN_C) begin
                p_now = diff;
            end
        end
    end

    // Next state: enable low always wins; pause selects between RUN and PAUSED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = pause ? ST_PAUSED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter, tick and latched period. The counter advances only in RUN with
    // enable high and pause low, so a pause request freezes the count in the
    // same cycle it arrives. IDLE keeps reloading the period so that a fresh
    // run starts with the period for the current level.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        tick_d   = 1'b0;
        advance  = (state_q == ST_RUN) && enable && !pause;
        last     = ({1'b0, cnt_q} == (period_q - PW'(1)));
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                period_d = p_now;
            end
            ST_RUN: begin
                if (!enable) begin
                    cnt_d = '0;
                end else if (advance) begin
                    if (last) begin
                        cnt_d    = '0;
                        tick_d   = 1'b1;
                        period_d = p_now;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (!enable) begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Speed level: clear beats increment; increment saturates at the top level.
    always_comb begin
        level_d = level_q;
        if (speed_clr) begin
            level_d = '0;
        end else if (speed_up && (level_q != LVL_MAX)) begin
            level_d = level_q + LVL_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= P0;
            level_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            level_q  <= level_d;
            tick_q   <= tick_d;
        end
    end

`ifdef SNAKE_TICK_SQUARE_EN
    logic tick_sq_q, tick_sq_d;

    // Square wave: flips together with each tick pulse, otherwise holds.
    always_comb begin
        tick_sq_d = tick_sq_q;
        if (tick_d) begin
            tick_sq_d = ~tick_sq_q;
        end
    end

    // Square-wave register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_sq_q <= 1'b0;
        end else begin
            tick_sq_q <= tick_sq_d;
        end
    end

    assign tick_sq = tick_sq_q;
`endif

    assign tick    = tick_q;
    assign level   = level_q;
    assign at_max  = (level_q == LVL_MAX);
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_snake_tick_gen.sv
// Bench for snake_tick_gen with a small configuration (period 10, step 2, floor 4,
// 4 levels). The stimulus pushes the hand-computed cycle number of each expected
// tick into a queue. A monitor pops an entry whenever the DUT ticks and
// compares the cycle numbers. Cycle n is the state after the n-th rising edge.
// Inputs are driven, and outputs sampled, on falling edges.
module tb_snake_tick_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pause = 1'b0;
    logic       speed_up = 1'b0;
    logic       speed_clr = 1'b0;
    logic       tick;
    logic [1:0] level;
    logic       at_max;
    logic       running;
`ifdef SNAKE_TICK_SQUARE_EN
    logic       tick_sq;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];
    int mon_e;

    snake_tick_gen #(
        .BASE_PERIOD(10), .STEP(2), .MIN_PERIOD(4), .LEVELS(4), .CNT_W(5)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause),
        .speed_up(speed_up), .speed_clr(speed_clr),
        .tick(tick), .level(level), .at_max(at_max), .running(running)
`ifdef SNAKE_TICK_SQUARE_EN
        , .tick_sq(tick_sq)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick must match the oldest expected cycle; an expected
    // cycle that passes without a tick is reported as missed.
    always @(negedge clk) begin
        if (tick) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick at cycle %0d, none expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e) begin
                    bad++;
                    $display("FAIL tick_cycle got=%0d want=%0d", cyc, mon_e);
                end
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0]) begin
            total++;
            bad++;
            mon_e = exp_q.pop_front();
            $display("FAIL missed_tick got=none want=%0d (now %0d)", mon_e, cyc);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic go_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int t;
        int r;
        int per[4];
        int lvl[4];
        per = '{10, 8, 6, 4};
        lvl = '{1, 2, 3, 3};

        repeat (3) step();
        chk("rst_running", running, 0);
        chk("rst_tick", tick, 0);
        chk("rst_level", level, 0);
        chk("rst_at_max", at_max, 0);

        // Release reset with enable high: ticks every 10 cycles from the first RUN cycle.
        reset = 1'b0; enable = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back(t0 + 10);
        exp_q.push_back(t0 + 20);
        exp_q.push_back(t0 + 30);
        go_until(t0 + 2);
        chk("run_running", running, 1);
        chk("run_level", level, 0);
        go_until(t0 + 30);
        t = t0 + 30;

        // Speed up on each tick: the new period applies from the following wrap.
        for (int i = 0; i < 4; i++) begin
            speed_up = 1'b1;
            exp_q.push_back(t + per[i]);
            step();
            speed_up = 1'b0;
            chk($sformatf("spd_level%0d", i), level, lvl[i]);
            t = t + per[i];
            go_until(t);
        end
        chk("spd_at_max", at_max, 1);
        exp_q.push_back(t + 4);
        go_until(t + 4);
        t = t + 4;

        // Clear back to level 0: the period in flight still completes at 4.
        speed_clr = 1'b1;
        exp_q.push_back(t + 4);
        step();
        speed_clr = 1'b0;
        chk("clr_level", level, 0);
        chk("clr_at_max", at_max, 0);
        go_until(t + 4);
        t = t + 4;

        // Raise to level 2, then assert clear and up together: clear wins.
        exp_q.push_back(t + 10);
        exp_q.push_back(t + 20);
        speed_up = 1'b1;
        step();
        step();
        chk("both_pre_level", level, 2);
        speed_clr = 1'b1;
        step();
        speed_up = 1'b0; speed_clr = 1'b0;
        chk("both_level", level, 0);
        go_until(t + 20);
        t = t + 20;

        // Pause at count 5 for 7 cycles; the count resumes from 5.
        go_until(t + 5);
        pause = 1'b1;
        repeat (3) step();
        chk("pause_running", running, 0);
        go_until(t + 12);
        pause = 1'b0;
        exp_q.push_back(t + 18);
        go_until(t + 13);
        chk("resume_running", running, 1);
        go_until(t + 18);
        t = t + 18;

        // Drop enable at count 7: the period is aborted and the counter cleared.
        go_until(t + 7);
        enable = 1'b0;
        step();
        chk("idle_running", running, 0);
        go_until(t + 10);
        enable = 1'b1;
        r = t + 11;
        exp_q.push_back(r + 10);
        go_until(r + 1);
        chk("reen_running", running, 1);
        chk("reen_level", level, 0);
        go_until(r + 10);
        t = r + 10;

`ifdef SNAKE_TICK_SQUARE_EN
        chk("sq_before_rst", tick_sq, 1);
`endif
        // Reset mid-period after a speed-up: no tick, and level returns to 0.
        speed_up = 1'b1;
        step();
        speed_up = 1'b0;
        go_until(t + 4);
        reset = 1'b1;
        step();
        chk("mid_rst_running", running, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_at_max", at_max, 0);
        chk("mid_rst_tick", tick, 0);
`ifdef SNAKE_TICK_SQUARE_EN
        chk("mid_rst_sq", tick_sq, 0);
`endif
        step();
        reset = 1'b0;
        r = cyc + 1;
        exp_q.push_back(r + 10);
        exp_q.push_back(r + 20);
        exp_q.push_back(r + 30);
        go_until(r + 33);
`ifdef SNAKE_TICK_SQUARE_EN
        chk("sq_after3", tick_sq, 1);
`endif

        // Drain: any tick still outstanding was never produced.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL pending_tick got=none want=%0d", exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
